fht_frame_sched: RTL and testbench
==================================

Name: fht_frame_sched

Overview:
- Host-side sequencer for the FHT core (4-bank RAM A, control, butterfly and ROM).
- Accepts a serial valid/ready sample stream and writes N = 4*2^A_BIT points into the core's RAM A banks.
- Pulses the core's start, waits for completion, then reads the 4 banks back and emits the spectrum as a serial valid/ready stream in natural index order.
- Sits between the ADC/stream fabric and the FHT core top level.

Parameters:
- D_BIT, 16, sample and result width.
- A_BIT, 8, bank address width; bank depth 2^A_BIT; N = 4*2^A_BIT.
- TIMEOUT, 65535, maximum cycles in WAIT; used only with FHT_SCHED_TIMEOUT_EN.

Ports:
- iCLK  in  1  clock; single clock domain.
- iRESET  in  1  synchronous, active-high reset.
- iS_VALID  in  1  input sample valid.
- iS_DATA  in  D_BIT  input sample.
- oS_READY  out  1  input sample accepted when iS_VALID & oS_READY.
- oWE  out  4  one-hot bank write enable to core iWE.
- oADDR_WR  out  A_BIT  write address to core.
- oDATA  out  D_BIT  write data to core.
- oSTART  out  1  one-cycle start pulse to core.
- iCORE_RDY  in  1  core oRDY level.
- oADDR_RD  out  A_BIT  read address, fanned to all 4 core read ports.
- iRD_0..iRD_3  in  D_BIT each  core oDATA_0..3.
- oM_VALID  out  1  output result valid.
- oM_DATA  out  D_BIT  output result, signed.
- oM_LAST  out  1  marks point N-1.
- iM_READY  in  1  output backpressure.
- oBUSY  out  1  high in every state except IDLE.
- oFRAME_CNT  out  8  completed frames; wraps at 255 to 0.
- oERR  out  1  sticky timeout flag.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. A reset mid-frame abandons the frame, and no oSTART is issued. oERR clears only on reset.
- States: IDLE, LOAD, START, WAIT, RD, CAP, SEND.
- IDLE and LOAD: oS_READY=1.
  - Point index i (0..N-1) maps to bank i[1:0], address i>>2.
  - A handshake at cycle t registers oWE=1<<i[1:0], oADDR_WR and oDATA, visible at t+1 for exactly 1 cycle.
  - IDLE moves to LOAD on the first handshake.
- LOAD→START after handshake i=N-1. oS_READY drops in the same cycle as that handshake, so no extra sample is accepted.
- START: oSTART=1 for exactly one cycle. It is asserted 2 cycles after the last handshake, so the last write is already committed.
- WAIT: rdy_q registers iCORE_RDY. Exit to RD on rising edge iCORE_RDY & ~rdy_q. A level already high on WAIT entry is ignored until it falls and rises again.
- RD: drive oADDR_RD=g, where g is the group counter 0..2^A_BIT-1. Core RAM read latency is 1 cycle.
- CAP: latch iRD_0..3 into a 4-entry holding buffer; j=0.
- SEND:
  - oM_VALID=1 and oM_DATA=buf[j].
  - On iM_READY, j increments.
  - While iM_READY=0, oM_DATA and oM_LAST stay stable.
  - After j=3: if g<2^A_BIT-1, then g++ and go to RD.
  - Otherwise oM_LAST is asserted with that beat, then oFRAME_CNT++ and go to IDLE.
- Output index = 4*g + j; throughput is 4 beats per 6 cycles without backpressure.
- oADDR_RD holds its last value outside RD/CAP.
- A new frame can be loaded only after unload finishes; oS_READY=0 from START to end of SEND.

Optional Feature:
- FHT_SCHED_TIMEOUT_EN defined:
  - A counter runs in WAIT.
  - Reaching TIMEOUT cycles without a rising edge sets oERR=1 and forces IDLE without unload.
  - oFRAME_CNT is not incremented.
- FHT_SCHED_TIMEOUT_EN undefined: WAIT is unbounded, and oERR is tied to 0.

Decomposition:
- Shared package/defines:
  - state encoding constants (3-bit);
  - N_BANK=4;
  - D_BIT/A_BIT defaults from the existing FHT defines.
- One sub-module: fht_sched_unload, holding the RD/CAP/SEND holding buffer, the j counter and the valid/ready output logic.
- Load, start and wait FSM stays in the top.

Test Plan:
1. A_BIT=2 (N=16): stream 0..15 with continuous valid.
   - oWE follows 1,2,4,8 repeating; oADDR_WR goes 0,0,0,0,1,...
   - oSTART is a single pulse 2 cycles after the 16th handshake.
2. Core model raises iCORE_RDY 40 cycles after oSTART; banks return value = 4*addr+bank.
   - oM_DATA = 0..15 in order; oM_LAST on 15; oFRAME_CNT=1.
3. Hold iM_READY=0 for 5 cycles at beat 6.
   - oM_DATA stays 6 and valid stays high; no beat is lost or duplicated.
4. Deassert iS_VALID randomly during load: the same writes occur, and oSTART is issued only after 16 handshakes.
5. Assert iRESET at handshake 9: all outputs 0; the next frame starts at bank 0, address 0; no oSTART for the aborted frame.
6. With FHT_SCHED_TIMEOUT_EN and TIMEOUT=100, hold iCORE_RDY=0.
   - oERR=1 at WAIT cycle 100; returns to IDLE; oM_VALID never asserted.

Source files
------------

// File: rtl/fht_frame_sched_pkg.sv
// Shared constants and state encoding for the FHT frame sequencer.
package fht_frame_sched_pkg;

  localparam int unsigned N_BANK    = 4;
  localparam int unsigned D_BIT_DEF = 16;
  localparam int unsigned A_BIT_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RD    = 3'd4,
    ST_CAP   = 3'd5,
    ST_SEND  = 3'd6
  } state_t;

endpackage

// File: rtl/fht_sched_unload.sv
// Unload path: captures one 4-bank read group and serialises it as a
// valid/ready stream, holding data and last stable under backpressure.
module fht_sched_unload
  import fht_frame_sched_pkg::*;
#(
  parameter int unsigned D_BIT = D_BIT_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cap,
  input  logic                           last_grp,
  input  logic [N_BANK-1:0][D_BIT-1:0]   rd_data,
  input  logic                           m_ready,
  output logic                           m_valid,
  output logic [D_BIT-1:0]               m_data,
  output logic                           m_last,
  output logic                           grp_done
);

  localparam int unsigned J_W = $clog2(N_BANK);

  logic [D_BIT-1:0] hold [N_BANK];
  logic [J_W-1:0]   j;
  logic             valid;
  logic             j_last;

  assign j_last   = (j == J_W'(N_BANK - 1));
  assign grp_done = valid & m_ready & j_last;
  assign m_valid  = valid;
  assign m_data   = hold[j];
  assign m_last   = valid & last_grp & j_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      j     <= '0;
      for (int unsigned b = 0; b < N_BANK; b++) hold[b] <= '0;
    end else if (cap) begin
      for (int unsigned b = 0; b < N_BANK; b++) hold[b] <= rd_data[b];
      j     <= '0;
      valid <= 1'b1;
    end else if (valid && m_ready) begin
      j <= j + 1'b1;
      if (j_last) valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fht_frame_sched.sv
// Host-side load/start/wait/unload sequencer for the 4-bank FHT core.
// Optional WAIT timeout with sticky oERR: define FHT_SCHED_TIMEOUT_EN.
module fht_frame_sched
  import fht_frame_sched_pkg::*;
#(
  parameter int unsigned D_BIT   = D_BIT_DEF,
  parameter int unsigned A_BIT   = A_BIT_DEF,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic               iCLK,
  input  logic               iRESET,
  input  logic               iS_VALID,
  input  logic [D_BIT-1:0]   iS_DATA,
  output logic               oS_READY,
  output logic [N_BANK-1:0]  oWE,
  output logic [A_BIT-1:0]   oADDR_WR,
  output logic [D_BIT-1:0]   oDATA,
  output logic               oSTART,
  input  logic               iCORE_RDY,
  output logic [A_BIT-1:0]   oADDR_RD,
  input  logic [D_BIT-1:0]   iRD_0,
  input  logic [D_BIT-1:0]   iRD_1,
  input  logic [D_BIT-1:0]   iRD_2,
  input  logic [D_BIT-1:0]   iRD_3,
  output logic               oM_VALID,
  output logic [D_BIT-1:0]   oM_DATA,
  output logic               oM_LAST,
  input  logic               iM_READY,
  output logic               oBUSY,
  output logic [7:0]         oFRAME_CNT,
  output logic               oERR
);

  localparam int unsigned IDX_W = A_BIT + 2;

  state_t                        state;
  logic [IDX_W-1:0]              idx;
  logic [A_BIT-1:0]              grp;
  logic                          rdy_q;
  logic                          grp_done;
  logic [N_BANK-1:0][D_BIT-1:0]  rd_bus;

`ifdef FHT_SCHED_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;
`else
  assign oERR = 1'b0;
`endif

  assign rd_bus = {iRD_3, iRD_2, iRD_1, iRD_0};
  assign oBUSY  = (state != ST_IDLE);

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state      <= ST_IDLE;
      idx        <= '0;
      grp        <= '0;
      rdy_q      <= 1'b0;
      oS_READY   <= 1'b0;
      oWE        <= '0;
      oADDR_WR   <= '0;
      oDATA      <= '0;
      oSTART     <= 1'b0;
      oADDR_RD   <= '0;
      oFRAME_CNT <= '0;
`ifdef FHT_SCHED_TIMEOUT_EN
      to_cnt     <= '0;
      oERR       <= 1'b0;
`endif
    end else begin
      oWE    <= '0;
      oSTART <= 1'b0;
      rdy_q  <= iCORE_RDY;
      case (state)
        ST_IDLE, ST_LOAD: begin
          oS_READY <= 1'b1;
          if (iS_VALID && oS_READY) begin
            oWE      <= {{(N_BANK-1){1'b0}}, 1'b1} << idx[1:0];
            oADDR_WR <= idx[IDX_W-1:2];
            oDATA    <= iS_DATA;
            idx      <= idx + 1'b1;
            state    <= ST_LOAD;
            // Ready drops on the final handshake so no N+1th sample slips in.
            if (&idx) begin
              oS_READY <= 1'b0;
              state    <= ST_START;
            end
          end
        end
        ST_START: begin
          oSTART <= 1'b1;
          idx    <= '0;
          grp    <= '0;
          state  <= ST_WAIT;
`ifdef FHT_SCHED_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end
        ST_WAIT: begin
          if (iCORE_RDY && !rdy_q) begin
            oADDR_RD <= grp;
            state    <= ST_RD;
          end
`ifdef FHT_SCHED_TIMEOUT_EN
          else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            oERR  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        ST_RD:   state <= ST_CAP;
        ST_CAP:  state <= ST_SEND;
        ST_SEND: begin
          if (grp_done) begin
            if (&grp) begin
              oFRAME_CNT <= oFRAME_CNT + 1'b1;
              state      <= ST_IDLE;
            end else begin
              grp      <= grp + 1'b1;
              oADDR_RD <= grp + 1'b1;
              state    <= ST_RD;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  fht_sched_unload #(
    .D_BIT (D_BIT)
  ) u_unload (
    .clk      (iCLK),
    .reset    (iRESET),
    .cap      (state == ST_CAP),
    .last_grp (&grp),
    .rd_data  (rd_bus),
    .m_ready  (iM_READY),
    .m_valid  (oM_VALID),
    .m_data   (oM_DATA),
    .m_last   (oM_LAST),
    .grp_done (grp_done)
  );

endmodule

// File: tb/tb_fht_frame_sched.sv
// Directed bench for fht_frame_sched with N=16 and a behavioural 4-bank core.
module tb_fht_frame_sched;

  logic        iCLK = 1'b0;
  logic        iRESET;
  logic        iS_VALID;
  logic [15:0] iS_DATA;
  logic        oS_READY;
  logic [3:0]  oWE;
  logic [1:0]  oADDR_WR;
  logic [15:0] oDATA;
  logic        oSTART;
  logic        iCORE_RDY;
  logic [1:0]  oADDR_RD;
  logic [15:0] iRD_0, iRD_1, iRD_2, iRD_3;
  logic        oM_VALID;
  logic [15:0] oM_DATA;
  logic        oM_LAST;
  logic        iM_READY;
  logic        oBUSY;
  logic [7:0]  oFRAME_CNT;
  logic        oERR;

  int total = 0;
  int bad   = 0;

  always #5 iCLK = ~iCLK;

  fht_frame_sched #(
    .D_BIT   (16),
    .A_BIT   (2),
    .TIMEOUT (100)
  ) dut (
    .iCLK       (iCLK),
    .iRESET     (iRESET),
    .iS_VALID   (iS_VALID),
    .iS_DATA    (iS_DATA),
    .oS_READY   (oS_READY),
    .oWE        (oWE),
    .oADDR_WR   (oADDR_WR),
    .oDATA      (oDATA),
    .oSTART     (oSTART),
    .iCORE_RDY  (iCORE_RDY),
    .oADDR_RD   (oADDR_RD),
    .iRD_0      (iRD_0),
    .iRD_1      (iRD_1),
    .iRD_2      (iRD_2),
    .iRD_3      (iRD_3),
    .oM_VALID   (oM_VALID),
    .oM_DATA    (oM_DATA),
    .oM_LAST    (oM_LAST),
    .iM_READY   (iM_READY),
    .oBUSY      (oBUSY),
    .oFRAME_CNT (oFRAME_CNT),
    .oERR       (oERR)
  );

  // Core model: 4 banks x 4 words, 1-cycle read, ready drops on start and
  // rises 40 cycles later unless held off.
  logic [15:0] mem [4][4];
  logic [15:0] rd_q [4];
  int          rdy_cnt;
  logic        core_rdy;
  logic        core_hold = 1'b0;

  assign iCORE_RDY = core_rdy;
  assign iRD_0 = rd_q[0];
  assign iRD_1 = rd_q[1];
  assign iRD_2 = rd_q[2];
  assign iRD_3 = rd_q[3];

  always @(posedge iCLK) begin
    for (int b = 0; b < 4; b++) begin
      if (oWE[b]) mem[b][oADDR_WR] <= oDATA;
      rd_q[b] <= mem[b][oADDR_RD];
    end
    if (iRESET) begin
      core_rdy <= 1'b1;
      rdy_cnt  <= 0;
    end else if (oSTART) begin
      core_rdy <= 1'b0;
      rdy_cnt  <= 40;
    end else if (rdy_cnt > 0) begin
      rdy_cnt <= rdy_cnt - 1;
      if (rdy_cnt == 1 && !core_hold) core_rdy <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready", 32'(oS_READY), 0);
    chk("rst_we", 32'(oWE), 0);
    chk("rst_addr_wr", 32'(oADDR_WR), 0);
    chk("rst_data", 32'(oDATA), 0);
    chk("rst_start", 32'(oSTART), 0);
    chk("rst_addr_rd", 32'(oADDR_RD), 0);
    chk("rst_m_valid", 32'(oM_VALID), 0);
    chk("rst_m_data", 32'(oM_DATA), 0);
    chk("rst_m_last", 32'(oM_LAST), 0);
    chk("rst_busy", 32'(oBUSY), 0);
    chk("rst_frame_cnt", 32'(oFRAME_CNT), 0);
    chk("rst_err", 32'(oERR), 0);
  endtask

  // Drives samples base+k under a valid pattern until n_hs handshakes occurred.
  task automatic load_frame(input int base, input logic [31:0] vpat, input int n_hs);
    int   k = 0;
    int   cyc = 0;
    logic hs;
    while (k < n_hs && cyc < 200) begin
      iS_VALID = vpat[cyc % 32];
      iS_DATA  = 16'(base + k);
      hs       = iS_VALID & oS_READY;
      @(negedge iCLK);
      cyc++;
      if (hs) begin
        chk("we", 32'(oWE), 32'(1 << (k % 4)));
        chk("addr_wr", 32'(oADDR_WR), 32'(k / 4));
        chk("wr_data", 32'(oDATA), 32'(base + k));
        k++;
      end else begin
        chk("we_idle", 32'(oWE), 0);
      end
      chk("start_during_load", 32'(oSTART), 0);
    end
    chk("load_handshakes", 32'(k), 32'(n_hs));
  endtask

  // Called at the negedge where the 16th write is visible.
  task automatic post_load();
    chk("ready_drop", 32'(oS_READY), 0);
    iS_VALID = 1'b1;
    iS_DATA  = 16'hDEAD;
    @(negedge iCLK);
    chk("start_pulse", 32'(oSTART), 1);
    chk("no_extra_write", 32'(oWE), 0);
    chk("ready_low_start", 32'(oS_READY), 0);
    @(negedge iCLK);
    chk("start_one_cycle", 32'(oSTART), 0);
    chk("busy_wait", 32'(oBUSY), 1);
    iS_VALID = 1'b0;
  endtask

  task automatic unload(input int base, input int stall_at, output int span);
    int   idx = 0;
    int   cyc = 0;
    int   first = -1;
    int   stall = 0;
    logic rdy;
    logic stalled_prev = 1'b0;
    span = -1;
    while (idx < 16 && cyc < 400) begin
      if (stalled_prev) chk("valid_hold", 32'(oM_VALID), 1);
      if (oM_VALID) begin
        if (first < 0) first = cyc;
        chk("m_data", 32'(oM_DATA), 32'(base + idx));
        chk("m_last", 32'(oM_LAST), 32'(idx == 15));
        chk("ready_low_send", 32'(oS_READY), 0);
      end
      rdy = !(oM_VALID && idx == stall_at && stall < 5);
      if (!rdy) stall++;
      stalled_prev = !rdy;
      iM_READY = rdy;
      if (oM_VALID && rdy) begin
        idx++;
        if (idx == 16) span = cyc - first;
      end
      @(negedge iCLK);
      cyc++;
    end
    iM_READY = 1'b1;
    chk("beats", 32'(idx), 16);
    chk("wait_for_core", 32'(first >= 40), 1);
    chk("valid_after_last", 32'(oM_VALID), 0);
    chk("busy_after_frame", 32'(oBUSY), 0);
    chk("addr_rd_hold", 32'(oADDR_RD), 3);
  endtask

  initial begin
    int   span;
    logic seen;
    iRESET   = 1'b1;
    iS_VALID = 1'b0;
    iS_DATA  = '0;
    iM_READY = 1'b1;
    repeat (3) @(negedge iCLK);
    chk_reset_outputs();
    iRESET = 1'b0;
    @(negedge iCLK);
    chk("idle_ready", 32'(oS_READY), 1);
    chk("idle_busy", 32'(oBUSY), 0);

    // Frame A: continuous stream 0..15, no backpressure.
    load_frame(0, 32'hFFFF_FFFF, 16);
    post_load();
    unload(0, -1, span);
    chk("span_no_stall", 32'(span), 21);
    chk("frame_cnt_a", 32'(oFRAME_CNT), 1);
    chk("err_default", 32'(oERR), 0);

    // Frame B: gapped valid, stall 5 cycles on beat 6.
    @(negedge iCLK);
    chk("ready_back", 32'(oS_READY), 1);
    load_frame(100, 32'hB5D3_6E9B, 16);
    post_load();
    unload(100, 6, span);
    chk("span_stall", 32'(span), 26);
    chk("frame_cnt_b", 32'(oFRAME_CNT), 2);

    // Frame C aborted by reset after 9 handshakes.
    @(negedge iCLK);
    load_frame(200, 32'hFFFF_FFFF, 9);
    iRESET   = 1'b1;
    iS_VALID = 1'b0;
    @(negedge iCLK);
    chk_reset_outputs();
    iRESET = 1'b0;
    seen   = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge iCLK);
      if (oSTART) seen = 1'b1;
    end
    chk("no_start_aborted", 32'(seen), 0);

    // Frame D restarts from bank 0 address 0.
    load_frame(300, 32'hFFFF_FFFF, 16);
    post_load();
    unload(300, -1, span);
    chk("frame_cnt_d", 32'(oFRAME_CNT), 1);

`ifdef FHT_SCHED_TIMEOUT_EN
    begin
      int   c = 1;
      logic early = 1'b0;
      logic vseen = 1'b0;
      core_hold = 1'b1;
      @(negedge iCLK);
      load_frame(400, 32'hFFFF_FFFF, 16);
      post_load();
      while (c < 100) begin
        @(negedge iCLK);
        c++;
        if (c < 100 && oERR) early = 1'b1;
        if (oM_VALID) vseen = 1'b1;
      end
      chk("err_early", 32'(early), 0);
      chk("err_timeout", 32'(oERR), 1);
      chk("timeout_idle", 32'(oBUSY), 0);
      chk("timeout_no_valid", 32'(vseen), 0);
      chk("timeout_frame_cnt", 32'(oFRAME_CNT), 1);
      core_hold = 1'b0;
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
